// File: rtl/hdmi_pattern_scheduler.sv
// Frame-synchronous test-pattern selector for the HDMI test datapath.
// Host requests are held until the next frame_start; an optional auto
// timer advances the pattern every FRAMES_PER_PATTERN frames. A host
// change applied on a frame boundary takes priority over an auto advance.
module hdmi_pattern_scheduler #(
  parameter int unsigned NUM_PATTERNS       = 6,
  parameter int unsigned PAT_W              = 3,
  parameter int unsigned FRAMES_PER_PATTERN = 60,
  parameter int unsigned FCNT_W             = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              auto_en,
  input  logic              req_valid,
  input  logic [PAT_W-1:0]  req_pattern,
  output logic              req_ready,
  output logic [PAT_W-1:0]  pattern_sel,
  output logic              pattern_update,
  output logic              pending,
  output logic              bad_req,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    WAIT_FRAME = 1'b1
  } state_t;

  localparam logic [PAT_W:0]    LP_NUM_PAT  = (PAT_W+1)'(NUM_PATTERNS);
  localparam logic [PAT_W-1:0]  LP_LAST_PAT = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [FCNT_W-1:0] LP_LAST_CNT = FCNT_W'(FRAMES_PER_PATTERN - 1);

  state_t              r_state;
  logic [PAT_W-1:0]    r_pend;
  logic [PAT_W-1:0]    r_pattern_sel;
  logic                r_update;
  logic                r_pending;
  logic                r_bad;
  logic [FCNT_W-1:0]   r_frame_cnt;

  logic                w_code_legal;
  logic                w_req_legal;
  logic                w_host_apply;
  logic [PAT_W-1:0]    w_apply_code;

  // Request classification and the code a frame boundary would commit;
  // a legal request on the boundary cycle bypasses the pending register.
  always_comb begin
    w_code_legal = ({1'b0, req_pattern} < LP_NUM_PAT);
    w_req_legal  = req_valid && w_code_legal;
    w_host_apply = frame_start && (w_req_legal || (r_state == WAIT_FRAME));
    w_apply_code = w_req_legal ? req_pattern : r_pend;
  end

  // Scheduler FSM with registered pattern, pulse and counter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pend        <= '0;
      r_pattern_sel <= '0;
      r_update      <= 1'b0;
      r_pending     <= 1'b0;
      r_bad         <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_update <= 1'b0;
      r_bad    <= req_valid && !w_code_legal;

      if (w_host_apply) begin
        r_pattern_sel <= w_apply_code;
        r_update      <= 1'b1;
        r_frame_cnt   <= '0;
        r_pending     <= 1'b0;
        r_state       <= IDLE;
      end else begin
        if (w_req_legal) begin
          r_pend    <= req_pattern;
          r_pending <= 1'b1;
          r_state   <= WAIT_FRAME;
        end
        if (frame_start && auto_en) begin
          if (r_frame_cnt == LP_LAST_CNT) begin
            r_pattern_sel <= (r_pattern_sel == LP_LAST_PAT) ? '0 : r_pattern_sel + 1'b1;
            r_update      <= 1'b1;
            r_frame_cnt   <= '0;
          end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
      end

      // Counter only runs while auto mode is enabled.
      if (!auto_en) begin
        r_frame_cnt <= '0;
      end
    end
  end

  assign req_ready      = 1'b1;
  assign pattern_sel    = r_pattern_sel;
  assign pattern_update = r_update;
  assign pending        = r_pending;
  assign bad_req        = r_bad;
  assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_hdmi_pattern_scheduler.sv
// Self-checking bench for hdmi_pattern_scheduler: directed scenarios plus a
// randomized run compared against a behavioural model of the scheduling rules.
module tb_hdmi_pattern_scheduler;

  localparam int NP  = 6;
  localparam int PW  = 3;
  localparam int FPP = 3;
  localparam int FW  = 8;

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic          auto_en;
  logic          req_valid;
  logic [PW-1:0] req_pattern;
  logic          req_ready;
  logic [PW-1:0] pattern_sel;
  logic          pattern_update;
  logic          pending;
  logic          bad_req;
  logic [FW-1:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: m_pend < 0 means no host change is waiting.
  int m_sel, m_upd, m_pend, m_bad, m_cnt;

  hdmi_pattern_scheduler #(
    .NUM_PATTERNS      (NP),
    .PAT_W             (PW),
    .FRAMES_PER_PATTERN(FPP),
    .FCNT_W            (FW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .auto_en       (auto_en),
    .req_valid     (req_valid),
    .req_pattern   (req_pattern),
    .req_ready     (req_ready),
    .pattern_sel   (pattern_sel),
    .pattern_update(pattern_update),
    .pending       (pending),
    .bad_req       (bad_req),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_sel = 0; m_upd = 0; m_pend = -1; m_bad = 0; m_cnt = 0;
  endtask

  // One clock: drive inputs, advance the model by the scheduling rules,
  // then leave time at posedge+1 so callers can sample outputs.
  task automatic step(input int fs, input int ae, input int rv, input int rp);
    int apply;
    frame_start = fs[0];
    auto_en     = ae[0];
    req_valid   = rv[0];
    req_pattern = PW'(rp);
    @(posedge clk);
    m_upd = 0;
    m_bad = (rv != 0 && rp >= NP) ? 1 : 0;
    apply = -1;
    if (fs != 0) begin
      if (rv != 0 && rp < NP) apply = rp;
      else if (m_pend >= 0)   apply = m_pend;
      if (apply >= 0) begin
        m_sel = apply; m_upd = 1; m_pend = -1; m_cnt = 0;
      end else if (ae != 0) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == FPP) begin
          m_cnt = 0;
          m_sel = (m_sel + 1) % NP;
          m_upd = 1;
        end
      end
    end else if (rv != 0 && rp < NP) begin
      m_pend = rp;
    end
    if (ae == 0) m_cnt = 0;
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    frame_start = 1'b0; auto_en = 1'b0; req_valid = 1'b0; req_pattern = '0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    frame_start = 1'b0; auto_en = 1'b0; req_valid = 1'b0; req_pattern = '0;
    #2;
    checks++;
    if ({pattern_sel, pattern_update, pending, bad_req, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: sel=%0d upd=%0b pend=%0b bad=%0b cnt=%0d, required all 0",
               pattern_sel, pattern_update, pending, bad_req, frame_cnt);
    end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_host_basic();
    step(0, 0, 1, 3);
    checks++;
    if (pending !== 1'b1 || pattern_sel !== 3'd0 || pattern_update !== 1'b0) begin
      errors++;
      $display("FAIL host_pending: pend=%b sel=%0d upd=%b, required 1/0/0", pending, pattern_sel, pattern_update);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (pattern_sel !== 3'd0 || pending !== 1'b1) begin
        errors++;
        $display("FAIL host_hold: sel=%0d pend=%b, required 0/1", pattern_sel, pending);
      end
    end
    step(1, 0, 0, 0);
    checks++;
    if (pattern_sel !== 3'd3 || pattern_update !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL host_apply: sel=%0d upd=%b pend=%b, required 3/1/0", pattern_sel, pattern_update, pending);
    end
    step(0, 0, 0, 0);
    checks++;
    if (pattern_update !== 1'b0 || pattern_sel !== 3'd3) begin
      errors++;
      $display("FAIL host_pulse_width: upd=%b sel=%0d, required 0/3", pattern_update, pattern_sel);
    end
  endtask

  task automatic test_latest_wins();
    int upd_cnt = 0;
    int saw2 = 0;
    step(0, 0, 1, 2);
    if (pattern_update === 1'b1) upd_cnt++;
    if (pattern_sel === 3'd2) saw2++;
    step(0, 0, 1, 4);
    if (pattern_update === 1'b1) upd_cnt++;
    if (pattern_sel === 3'd2) saw2++;
    step(1, 0, 0, 0);
    checks++;
    if (pattern_sel !== 3'd4 || pattern_update !== 1'b1) begin
      errors++;
      $display("FAIL latest_apply: sel=%0d upd=%b, required 4/1", pattern_sel, pattern_update);
    end
    if (pattern_update === 1'b1) upd_cnt++;
    step(0, 0, 0, 0);
    if (pattern_update === 1'b1) upd_cnt++;
    checks++;
    if (upd_cnt != 1 || saw2 != 0) begin
      errors++;
      $display("FAIL latest_single_pulse: pulses=%0d code2_seen=%0d, required 1/0", upd_cnt, saw2);
    end
  endtask

  task automatic test_bad_req();
    step(0, 0, 1, 7);
    checks++;
    if (bad_req !== 1'b1 || pattern_sel !== 3'd4 || pending !== 1'b0) begin
      errors++;
      $display("FAIL bad_pulse: bad=%b sel=%0d pend=%b, required 1/4/0", bad_req, pattern_sel, pending);
    end
    step(1, 0, 0, 0);
    checks++;
    if (bad_req !== 1'b0 || pattern_update !== 1'b0 || pattern_sel !== 3'd4) begin
      errors++;
      $display("FAIL bad_no_effect: bad=%b upd=%b sel=%0d, required 0/0/4", bad_req, pattern_update, pattern_sel);
    end
  endtask

  task automatic test_auto_wrap();
    int exp_cnt[4] = '{0, 1, 2, 0};
    step(1, 1, 1, 5);
    step(0, 1, 0, 0);
    checks++;
    if (pattern_sel !== 3'd5 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL auto_setup: sel=%0d cnt=%0d, required 5/0", pattern_sel, frame_cnt);
    end
    for (int f = 1; f <= 3; f++) begin
      step(1, 1, 0, 0);
      checks++;
      if (frame_cnt !== FW'(exp_cnt[f])) begin
        errors++;
        $display("FAIL auto_cnt: frame %0d cnt=%0d, required %0d", f, frame_cnt, exp_cnt[f]);
      end
      checks++;
      if ((f < 3 && (pattern_sel !== 3'd5 || pattern_update !== 1'b0)) ||
          (f == 3 && (pattern_sel !== 3'd0 || pattern_update !== 1'b1))) begin
        errors++;
        $display("FAIL auto_sel: frame %0d sel=%0d upd=%b", f, pattern_sel, pattern_update);
      end
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
    end
  endtask

  task automatic test_host_priority();
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (frame_cnt !== 8'd2 || pattern_sel !== 3'd0) begin
      errors++;
      $display("FAIL prio_setup: cnt=%0d sel=%0d, required 2/0", frame_cnt, pattern_sel);
    end
    step(1, 1, 1, 1);
    checks++;
    if (pattern_sel !== 3'd1 || frame_cnt !== 8'd0 || pattern_update !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL prio_apply: sel=%0d cnt=%0d upd=%b pend=%b, required 1/0/1/0",
               pattern_sel, frame_cnt, pattern_update, pending);
    end
    step(0, 1, 0, 0);
    checks++;
    if (pattern_sel !== 3'd1 || pattern_update !== 1'b0) begin
      errors++;
      $display("FAIL prio_no_advance: sel=%0d upd=%b, required 1/0", pattern_sel, pattern_update);
    end
  endtask

  task automatic test_reset_pending();
    step(0, 0, 1, 2);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL rstp_pending: pend=%b, required 1", pending);
    end
    apply_reset(2);
    checks++;
    if (pattern_sel !== 3'd0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL rstp_cleared: sel=%0d pend=%b, required 0/0", pattern_sel, pending);
    end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++;
    if (pattern_update !== 1'b0 || pattern_sel !== 3'd0) begin
      errors++;
      $display("FAIL rstp_no_update: upd=%b sel=%0d, required 0/0", pattern_update, pattern_sel);
    end
  endtask

  task automatic test_random();
    int gap = 2;
    int ae = 0;
    int fs, rv, rp;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) ae = 1 - ae;
      fs = 0;
      if (gap >= 2 && $urandom_range(0, 3) == 0) fs = 1;
      else if (gap == 1 && $urandom_range(0, 19) == 0) fs = 1;
      gap = fs ? 1 : gap + 1;
      rv = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rp = $urandom_range(0, 7);
      step(fs, ae, rv, rp);
      checks++;
      if (pattern_sel !== PW'(m_sel) || pattern_update !== m_upd[0] ||
          pending !== (m_pend >= 0) || bad_req !== m_bad[0] ||
          frame_cnt !== FW'(m_cnt) || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_cycle %0d: sel=%0d/%0d upd=%b/%0d pend=%b/%0d bad=%b/%0d cnt=%0d/%0d (actual/required)",
                 i, pattern_sel, m_sel, pattern_update, m_upd, pending, (m_pend >= 0),
                 bad_req, m_bad, frame_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_host_basic();
    test_latest_wins();
    test_bad_req();
    test_auto_wrap();
    test_host_priority();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
